// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parameterised register file: clear-FSM
// state encodings and the byte-enable merge used by writes and read bypass.
package reg_file_pkg;

    typedef logic [1:0] clr_state_t;

    localparam clr_state_t IDLE  = 2'd0;
    localparam clr_state_t CLEAR = 2'd1;
    localparam clr_state_t DONE  = 2'd2;

    // Widest entry the merge helper supports; callers cast to their own width.
    localparam int unsigned MERGE_MAX_W = 256;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]   old_data,
        input logic [MERGE_MAX_W-1:0]   new_data,
        input logic [MERGE_MAX_W/8-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_data;
        for (int unsigned i = 0; i < MERGE_MAX_W / 8; i++) begin
            if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// Registered read port: one-cycle latency, optional zero entry and optional
// forwarding of a same-cycle write to the addressed entry.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   entry,
    input  logic                wr_fire,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid
);

    logic [DATA_W-1:0] next_data;

    always_comb begin
        next_data = entry;
        if (ZERO_REG != 0 && rd_addr == '0) begin
            next_data = '0;
        end else if (BYPASS != 0 && wr_fire && wr_addr == rd_addr) begin
            next_data = DATA_W'(byte_merge(MERGE_MAX_W'(entry), MERGE_MAX_W'(wr_data),
                                           (MERGE_MAX_W/8)'(wr_be)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= next_data;
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// Parameterised 2-read/1-write register file with byte enables, optional
// zero entry, optional write-to-read bypass and a sequential clear engine.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd1_en,
    input  logic [ADDR_W-1:0]   rd1_addr,
    input  logic                rd2_en,
    input  logic [ADDR_W-1:0]   rd2_addr,
    output logic [DATA_W-1:0]   rd1_data,
    output logic [DATA_W-1:0]   rd2_data,
    output logic                rd1_valid,
    output logic                rd2_valid,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    clr_state_t        state;
    logic [ADDR_W-1:0] idx;
    logic              busy;
    logic              wr_fire;
    logic [DATA_W-1:0] wr_merged;

    assign busy      = (state == CLEAR);
    assign clr_busy  = busy;
    assign clr_done  = (state == DONE);
    assign wr_fire   = wr_en && !busy && !(ZERO_REG != 0 && wr_addr == '0);
    assign wr_merged = DATA_W'(byte_merge(MERGE_MAX_W'(mem[wr_addr]), MERGE_MAX_W'(wr_data),
                                          (MERGE_MAX_W/8)'(wr_be)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
                CLEAR: begin
                    idx <= idx + ADDR_W'(1);
                    if (idx == '1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A write sampled with clr_req in IDLE lands first; the clear zeroes it later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (busy) begin
            mem[idx] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd1 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd1_en && !busy),
        .rd_addr  (rd1_addr),
        .entry    (mem[rd1_addr]),
        .wr_fire  (wr_fire),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_data  (rd1_data),
        .rd_valid (rd1_valid)
    );

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd2 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd2_en && !busy),
        .rd_addr  (rd2_addr),
        .entry    (mem[rd2_addr]),
        .wr_fire  (wr_fire),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_data  (rd2_data),
        .rd_valid (rd2_valid)
    );

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench: a default 32x32 instance (bypass on) and a 8x64
// instance with a hard-wired zero entry and bypass off, scoreboard-checked.
module tb_reg_file_param;

    logic clk;
    logic rst;

    logic        a_wr_en, a_rd1_en, a_rd2_en, a_clr_req;
    logic [4:0]  a_wr_addr, a_rd1_addr, a_rd2_addr;
    logic [31:0] a_wr_data, a_rd1_data, a_rd2_data;
    logic [3:0]  a_wr_be;
    logic        a_rd1_valid, a_rd2_valid, a_clr_busy, a_clr_done;

    logic        b_wr_en, b_rd1_en, b_rd2_en, b_clr_req;
    logic [2:0]  b_wr_addr, b_rd1_addr, b_rd2_addr;
    logic [63:0] b_wr_data, b_rd1_data, b_rd2_data;
    logic [7:0]  b_wr_be;
    logic        b_rd1_valid, b_rd2_valid, b_clr_busy, b_clr_done;

    int tests = 0;
    int fails = 0;

    logic [31:0] ma [32];
    logic [63:0] mb [8];
    logic [31:0] qa1 [$], qa2 [$];
    logic [63:0] qb1 [$], qb2 [$];
    logic [31:0] la1, la2;
    logic [63:0] lb1, lb2;

    reg_file_param dut_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
        .rd1_en(a_rd1_en), .rd1_addr(a_rd1_addr), .rd2_en(a_rd2_en), .rd2_addr(a_rd2_addr),
        .rd1_data(a_rd1_data), .rd2_data(a_rd2_data),
        .rd1_valid(a_rd1_valid), .rd2_valid(a_rd2_valid),
        .clr_req(a_clr_req), .clr_busy(a_clr_busy), .clr_done(a_clr_done)
    );

    reg_file_param #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
        .rd1_en(b_rd1_en), .rd1_addr(b_rd1_addr), .rd2_en(b_rd2_en), .rd2_addr(b_rd2_addr),
        .rd1_data(b_rd1_data), .rd2_data(b_rd2_data),
        .rd1_valid(b_rd1_valid), .rd2_valid(b_rd2_valid),
        .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] n,
                                           input logic [7:0] be);
        logic [63:0] r;
        r = o;
        for (int k = 0; k < 8; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic idle_a();
        a_wr_en = 0; a_rd1_en = 0; a_rd2_en = 0; a_clr_req = 0;
        a_wr_addr = '0; a_rd1_addr = '0; a_rd2_addr = '0; a_wr_data = '0; a_wr_be = '0;
    endtask

    task automatic idle_b();
        b_wr_en = 0; b_rd1_en = 0; b_rd2_en = 0; b_clr_req = 0;
        b_wr_addr = '0; b_rd1_addr = '0; b_rd2_addr = '0; b_wr_data = '0; b_wr_be = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ma[i] = '0;
        for (int i = 0; i < 8; i++) mb[i] = '0;
        qa1.delete(); qa2.delete(); qb1.delete(); qb2.delete();
        la1 = '0; la2 = '0; lb1 = '0; lb2 = '0;
    endtask

    // Advance one edge and drain the scoreboard: a queued entry means a read
    // was issued last cycle and must appear now; otherwise valid=0, data held.
    task automatic tick();
        logic v;
        @(posedge clk); #1;
        v = (qa1.size() > 0); if (v) la1 = qa1.pop_front();
        tests++; if (a_rd1_valid !== v) begin fails++; $display("FAIL a_rd1_valid: got %b want %b", a_rd1_valid, v); end
        tests++; if (a_rd1_data !== la1) begin fails++; $display("FAIL a_rd1_data: got %h want %h", a_rd1_data, la1); end
        v = (qa2.size() > 0); if (v) la2 = qa2.pop_front();
        tests++; if (a_rd2_valid !== v) begin fails++; $display("FAIL a_rd2_valid: got %b want %b", a_rd2_valid, v); end
        tests++; if (a_rd2_data !== la2) begin fails++; $display("FAIL a_rd2_data: got %h want %h", a_rd2_data, la2); end
        v = (qb1.size() > 0); if (v) lb1 = qb1.pop_front();
        tests++; if (b_rd1_valid !== v) begin fails++; $display("FAIL b_rd1_valid: got %b want %b", b_rd1_valid, v); end
        tests++; if (b_rd1_data !== lb1) begin fails++; $display("FAIL b_rd1_data: got %h want %h", b_rd1_data, lb1); end
        v = (qb2.size() > 0); if (v) lb2 = qb2.pop_front();
        tests++; if (b_rd2_valid !== v) begin fails++; $display("FAIL b_rd2_valid: got %b want %b", b_rd2_valid, v); end
        tests++; if (b_rd2_data !== lb2) begin fails++; $display("FAIL b_rd2_data: got %h want %h", b_rd2_data, lb2); end
    endtask

    // One idle-state cycle on instance A (bypass on, entry 0 writable).
    task automatic a_drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [3:0] be, input logic r1, input logic [4:0] ra1,
                           input logic r2, input logic [4:0] ra2);
        logic [31:0] m;
        a_wr_en = wr; a_wr_addr = wa; a_wr_data = wd; a_wr_be = be;
        a_rd1_en = r1; a_rd1_addr = ra1; a_rd2_en = r2; a_rd2_addr = ra2;
        m = 32'(bmerge(64'(ma[wa]), 64'(wd), 8'(be)));
        if (r1) qa1.push_back((wr && wa == ra1) ? m : ma[ra1]);
        if (r2) qa2.push_back((wr && wa == ra2) ? m : ma[ra2]);
        if (wr) ma[wa] = m;
        tick();
        idle_a();
    endtask

    // One idle-state cycle on instance B (bypass off, entry 0 reads zero).
    task automatic b_drive(input logic wr, input logic [2:0] wa, input logic [63:0] wd,
                           input logic [7:0] be, input logic r1, input logic [2:0] ra1,
                           input logic r2, input logic [2:0] ra2);
        b_wr_en = wr; b_wr_addr = wa; b_wr_data = wd; b_wr_be = be;
        b_rd1_en = r1; b_rd1_addr = ra1; b_rd2_en = r2; b_rd2_addr = ra2;
        if (r1) qb1.push_back(ra1 == 0 ? 64'h0 : mb[ra1]);
        if (r2) qb2.push_back(ra2 == 0 ? 64'h0 : mb[ra2]);
        if (wr && wa != 0) mb[wa] = bmerge(mb[wa], wd, be);
        tick();
        idle_b();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_a(); idle_b(); model_reset();
        #3;
        tests++; if ({a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid, a_clr_busy, a_clr_done} !== '0) begin
            fails++; $display("FAIL reset_a_outputs: got %h %h %b%b%b%b want all zero",
                              a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid, a_clr_busy, a_clr_done); end
        tests++; if ({b_rd1_data, b_rd2_data, b_rd1_valid, b_rd2_valid, b_clr_busy, b_clr_done} !== '0) begin
            fails++; $display("FAIL reset_b_outputs: got %h %h %b%b%b%b want all zero",
                              b_rd1_data, b_rd2_data, b_rd1_valid, b_rd2_valid, b_clr_busy, b_clr_done); end
        #9 rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        a_drive(1, 5'd3, 32'hDEADBEEF, 4'hF, 0, 5'd0, 0, 5'd0);
        a_drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd3, 0, 5'd0);
        tests++; if (a_rd1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL a_read_addr3: got %h want deadbeef", a_rd1_data); end
        tick();
        b_drive(1, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 0, 3'd0, 0, 3'd0);
        b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'd3, 1, 3'd3);
        b_drive(1, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 8'b1000_0001, 0, 3'd0, 0, 3'd0);
        b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'd6, 0, 3'd0);
    endtask

    task automatic test_bypass();
        a_drive(1, 5'd5, 32'h11223344, 4'hF, 0, 5'd0, 0, 5'd0);
        a_drive(1, 5'd5, 32'hAABBCCDD, 4'b0101, 0, 5'd0, 1, 5'd5);
        tests++; if (a_rd2_data !== 32'h11BB33DD) begin fails++; $display("FAIL a_bypass: got %h want 11bb33dd", a_rd2_data); end
        a_drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd5, 1, 5'd5);
        b_drive(1, 3'd5, 64'h1122334455667788, 8'hFF, 0, 3'd0, 0, 3'd0);
        b_drive(1, 3'd5, 64'hAABBCCDDEEFF0011, 8'b0101_0101, 0, 3'd0, 1, 3'd5);
        tests++; if (b_rd2_data !== 64'h1122334455667788) begin fails++; $display("FAIL b_no_bypass: got %h want 1122334455667788", b_rd2_data); end
        b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'd5, 1, 3'd5);
        tests++; if (b_rd1_data !== 64'h11BB33DD55FF7711) begin fails++; $display("FAIL b_merged: got %h want 11bb33dd55ff7711", b_rd1_data); end
    endtask

    task automatic test_zero_reg();
        b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'd3, 1, 3'd5);
        b_drive(1, 3'd0, '1, 8'hFF, 1, 3'd0, 1, 3'd0);
        b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'd0, 1, 3'd0);
        tests++; if ({b_rd1_data, b_rd2_data} !== '0) begin fails++; $display("FAIL b_zero_reg: got %h %h want 0", b_rd1_data, b_rd2_data); end
        a_drive(1, 5'd0, 32'hCAFEF00D, 4'hF, 1, 5'd0, 0, 5'd0);
        a_drive(0, 5'd0, 32'h0, 4'h0, 0, 5'd0, 1, 5'd0);
    endtask

    task automatic test_dual_port();
        for (int n = 0; n < 40; n++) begin
            a_drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 4'($urandom),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            b_drive(1'($urandom_range(0, 1)), 3'($urandom), {$urandom, $urandom}, 8'($urandom),
                    1'($urandom_range(0, 1)), 3'($urandom),
                    1'($urandom_range(0, 1)), 3'($urandom));
        end
    endtask

    task automatic test_clear_a();
        int busy_cnt;
        for (int i = 0; i < 32; i++) a_drive(1, 5'(i), 32'hA5A50000 | 32'(i), 4'hF, 0, 5'd0, 0, 5'd0);
        a_clr_req = 1; a_wr_en = 1; a_wr_addr = 5'd7; a_wr_data = 32'h0BAD0BAD; a_wr_be = 4'hF;
        tick();
        idle_a();
        busy_cnt = 0;
        for (int c = 0; c < 40 && a_clr_busy === 1'b1; c++) begin
            busy_cnt++;
            tests++; if (a_clr_done !== 1'b0) begin fails++; $display("FAIL a_done_while_busy: got %b want 0", a_clr_done); end
            a_wr_en = 1; a_wr_addr = 5'd9; a_wr_data = '1; a_wr_be = 4'hF;
            a_rd1_en = 1; a_rd1_addr = 5'd9; a_clr_req = (c == 5);
            tick();
            idle_a();
        end
        for (int i = 0; i < 32; i++) ma[i] = '0;
        tests++; if (busy_cnt !== 32) begin fails++; $display("FAIL a_busy_cycles: got %0d want 32", busy_cnt); end
        tests++; if (a_clr_done !== 1'b1) begin fails++; $display("FAIL a_done_pulse: got %b want 1", a_clr_done); end
        a_clr_req = 1;
        tick();
        a_clr_req = 0;
        tests++; if ({a_clr_busy, a_clr_done} !== 2'b00) begin fails++; $display("FAIL a_req_in_done: got busy,done=%b%b want 00", a_clr_busy, a_clr_done); end
        for (int i = 0; i < 32; i++) a_drive(0, 5'd0, 32'h0, 4'h0, 1, 5'(i), 1, 5'(31 - i));
    endtask

    task automatic test_clear_b();
        int busy_cnt;
        for (int i = 0; i < 8; i++) b_drive(1, 3'(i), {32'hB0B00000 | 32'(i), 32'h0000C0C0}, 8'hFF, 0, 3'd0, 0, 3'd0);
        b_drive(1, 3'd2, 64'h0, 8'b0000_1100, 1, 3'd2, 0, 3'd0);
        b_clr_req = 1;
        tick();
        idle_b();
        busy_cnt = 0;
        for (int c = 0; c < 20 && b_clr_busy === 1'b1; c++) begin
            busy_cnt++;
            b_wr_en = 1; b_wr_addr = 3'd1; b_wr_data = '1; b_wr_be = 8'hFF;
            b_rd2_en = 1; b_rd2_addr = 3'd1;
            tick();
            idle_b();
        end
        for (int i = 0; i < 8; i++) mb[i] = '0;
        tests++; if (busy_cnt !== 8) begin fails++; $display("FAIL b_busy_cycles: got %0d want 8", busy_cnt); end
        tests++; if (b_clr_done !== 1'b1) begin fails++; $display("FAIL b_done_pulse: got %b want 1", b_clr_done); end
        tick();
        tests++; if (b_clr_done !== 1'b0) begin fails++; $display("FAIL b_done_width: got %b want 0", b_clr_done); end
        for (int i = 0; i < 8; i++) b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'(i), 1, 3'(7 - i));
    endtask

    task automatic test_reset_mid_clear();
        a_drive(1, 5'd4, 32'h12345678, 4'hF, 0, 5'd0, 0, 5'd0);
        a_drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd4, 1, 5'd4);
        b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'd5, 0, 3'd0);
        a_clr_req = 1;
        tick();
        idle_a();
        for (int c = 1; c < 10; c++) tick();
        #2 rst = 1'b1;
        #1;
        tests++; if ({a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid, a_clr_busy, a_clr_done} !== '0) begin
            fails++; $display("FAIL async_reset_a: got %h %h %b%b%b%b want all zero",
                              a_rd1_data, a_rd2_data, a_rd1_valid, a_rd2_valid, a_clr_busy, a_clr_done); end
        tests++; if (b_rd1_data !== 64'h0) begin fails++; $display("FAIL async_reset_b: got %h want 0", b_rd1_data); end
        model_reset();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            tests++; if ({a_clr_busy, a_clr_done} !== 2'b00) begin fails++; $display("FAIL a_after_abort: got busy,done=%b%b want 00", a_clr_busy, a_clr_done); end
        end
        a_drive(0, 5'd0, 32'h0, 4'h0, 1, 5'd4, 0, 5'd0);
        a_drive(1, 5'd4, 32'h00C0FFEE, 4'hF, 1, 5'd4, 0, 5'd0);
        a_drive(0, 5'd0, 32'h0, 4'h0, 0, 5'd0, 1, 5'd4);
        b_drive(0, 3'd0, 64'h0, 8'h00, 1, 3'd5, 1, 3'd3);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_dual_port();
        test_clear_a();
        test_clear_b();
        test_reset_mid_clear();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32: entry width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, entry 0 reads as zero and ignores writes.
REQ-004 SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to reads.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_data  input  DATA_W  write data.
REQ-011 wr_be  input  DATA_W/8  byte enables; bit i covers bits 8i+7..8i.
REQ-012 rd1_en, rd2_en  input  1  read requests, ports 1 and 2.
REQ-013 rd1_addr, rd2_addr  input  ADDR_W  read addresses.
REQ-014 rd1_data, rd2_data  output  DATA_W  registered read data.
REQ-015 rd1_valid, rd2_valid  output  1  one-cycle strobe: rdN_data is updated this cycle.
REQ-016 clr_req  input  1  start a sequential clear of all entries.
REQ-017 clr_busy  output  1  clear in progress.
REQ-018 clr_done  output  1  one-cycle pulse: clear complete.

Function
REQ-019 Write: when wr_en=1 and not blocked, SHALL update only the bytes of entry wr_addr whose wr_be bit is 1, at the rising edge.
REQ-020 Read latency SHALL be 1 cycle: rdN_en sampled at edge k -> rdN_data and rdN_valid=1 visible after edge k; rdN_valid=0 at all other times; rdN_data holds its value when not read.
REQ-021 With BYPASS=1 and a same-cycle write to the read address, rdN_data SHALL equal the stored entry with enabled bytes replaced by wr_data; with BYPASS=0 it SHALL return the pre-write entry.
REQ-022 With ZERO_REG=1, a read of address 0 SHALL return 0 (including bypass), and writes to address 0 SHALL be discarded.
REQ-023 Both read ports SHALL operate independently and concurrently, including on the same address.
REQ-024 Clear FSM states SHALL be IDLE, CLEAR and DONE.
REQ-025 IDLE -> CLEAR when clr_req=1; the index counter starts at 0.
REQ-026 In CLEAR, SHALL zero entry[index] each cycle and increment index; after index DEPTH-1, go to DONE. The clear lasts exactly DEPTH cycles.
REQ-027 DONE -> IDLE unconditionally after one cycle. clr_done=1 only in DONE.
REQ-028 clr_busy SHALL be 1 only in CLEAR.
REQ-029 While clr_busy=1, wr_en and rdN_en SHALL be ignored: no write, rdN_valid=0, rdN_data held. clr_req SHALL also be ignored.
REQ-030 A clr_req arriving in DONE SHALL be ignored.
REQ-031 clr_req and wr_en sampled together in IDLE: the write SHALL be performed, and the clear then zeroes that entry.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for a clock edge, clear all entries, rdN_data, rdN_valid, clr_busy and clr_done to 0, set the FSM to IDLE and the index to 0.
REQ-033 A reset asserted mid-clear SHALL abort the clear; no clr_done pulse follows.
REQ-034 On the first edge after rst deasserts, the block SHALL accept requests normally.

Structure
REQ-035 Package reg_file_pkg SHALL hold the clear-FSM state typedef (IDLE/CLEAR/DONE) and a byte-merge function (old, new, be).
REQ-036 Sub-module reg_file_rd_port (registered read port with bypass/zero logic) SHALL be instantiated twice.

Verification
REQ-037 Reset, write addr 3 = 0xDEADBEEF with be=4'hF, then read port 1 at addr 3 -> rd1_data=0xDEADBEEF and rd1_valid=1 exactly one cycle later.
REQ-038 Entry 5 = 0x11223344, write 0xAABBCCDD with be=4'b0101 while rd2 reads addr 5 in the same cycle -> BYPASS=1: 0x11BB33DD; BYPASS=0: 0x11223344; next read: 0x11BB33DD.
REQ-039 ZERO_REG=1: write addr 0 = 0xFFFFFFFF, read addr 0 on both ports -> both return 0x00000000.
REQ-040 Fill all 32 entries, pulse clr_req -> clr_busy high exactly 32 cycles, then clr_done pulses 1 cycle; a write attempted during busy has no effect; every entry then reads 0.
REQ-041 Assert rst at clear cycle 10 -> outputs 0 at once without a clock edge; no clr_done pulse; the FSM is IDLE.
REQ-042 DATA_W=64, ADDR_W=3: byte-enable write and clear behave as above; the clear lasts 8 cycles.
